// File: rtl/dpram_tdp_if.sv
// Bus bundle for the true dual-port RAM: two independent read/write ports
// plus the zero-fill request and the array-ready flag.
interface dpram_tdp_if #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 2048
);
  localparam int AW = (RAM_DEPTH > 2) ? $clog2(RAM_DEPTH) : 1;
  localparam int NB = RAM_WIDTH / 8;

  logic                 ena;
  logic                 wea;
  logic [NB-1:0]        wema;
  logic [AW-1:0]        addra;
  logic [RAM_WIDTH-1:0] dina;
  logic [RAM_WIDTH-1:0] douta;
  logic                 rvalida;

  logic                 enb;
  logic                 web;
  logic [NB-1:0]        wemb;
  logic [AW-1:0]        addrb;
  logic [RAM_WIDTH-1:0] dinb;
  logic [RAM_WIDTH-1:0] doutb;
  logic                 rvalidb;

  logic                 clr_req;
  logic                 init_done;

  // Requester side (fetch path / LSU / bench)
  modport master (
    output ena, wea, wema, addra, dina,
    output enb, web, wemb, addrb, dinb,
    output clr_req,
    input  douta, rvalida, doutb, rvalidb, init_done
  );

  // Memory side
  modport slave (
    input  ena, wea, wema, addra, dina,
    input  enb, web, wemb, addrb, dinb,
    input  clr_req,
    output douta, rvalida, doutb, rvalidb, init_done
  );
endinterface

// File: rtl/dpram_tdp.sv
// True dual-port RAM with byte strobes, read-first ports, optional output
// register, deterministic same-address write collision (port B wins per
// byte) and a hardware zero-fill state machine.
module dpram_tdp #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 2048,
  parameter int OUT_REG   = 0,
  parameter int INIT_ZERO = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  dpram_tdp_if.slave  bus
);
  localparam int AW = (RAM_DEPTH > 2) ? $clog2(RAM_DEPTH) : 1;
  localparam int NB = RAM_WIDTH / 8;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;
  localparam logic [0:0] S_RST   = (INIT_ZERO != 0) ? S_CLEAR : S_IDLE;
  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  logic [0:0]           state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;

  logic                 ready;
  logic                 clr_we;
  logic                 acc_a, acc_b;
  logic                 inr_a, inr_b;
  logic [NB-1:0]        wstb_a, wstb_b;
  logic [RAM_WIDTH-1:0] rd_a, rd_b;

  logic [RAM_WIDTH-1:0] douta_q, doutb_q;
  logic                 rvalida_q, rvalidb_q;

  // Non-power-of-two depths leave a hole at the top of the address space
  function automatic logic in_range(input logic [AW-1:0] addr);
    return 32'(addr) < 32'(RAM_DEPTH);
  endfunction

  assign ready = (state_q == S_IDLE);
  // Clear writes are held off while reset is asserted so the array is untouched by reset
  assign clr_we = (state_q == S_CLEAR) && rst_n;

  // Port qualification, collision masking and read-first data selection
  always_comb begin
    acc_a  = ready & bus.ena;
    acc_b  = ready & bus.enb;
    inr_a  = in_range(bus.addra);
    inr_b  = in_range(bus.addrb);
    wstb_b = (acc_b && bus.web && inr_b) ? bus.wemb : '0;
    wstb_a = (acc_a && bus.wea && inr_a) ? bus.wema : '0;
    // Same-address double write: port B owns every byte it strobes
    if (bus.addra == bus.addrb) begin
      wstb_a = wstb_a & ~wstb_b;
    end
    rd_a = inr_a ? mem[bus.addra] : '0;
    rd_b = inr_b ? mem[bus.addrb] : '0;
  end

  // Array update: zero-fill has exclusive access, otherwise byte-strobed port writes
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wstb_a[i]) mem[bus.addra][8*i +: 8] <= bus.dina[8*i +: 8];
        if (wstb_b[i]) mem[bus.addrb][8*i +: 8] <= bus.dinb[8*i +: 8];
      end
    end
  end

  // Zero-fill sequencer: IDLE waits for clr_req, CLEAR walks every address once
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.clr_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state; an aborted fill restarts from address 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // First read stage: capture on accepted access, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      douta_q   <= '0;
      doutb_q   <= '0;
      rvalida_q <= 1'b0;
      rvalidb_q <= 1'b0;
    end else begin
      rvalida_q <= acc_a;
      rvalidb_q <= acc_b;
      if (acc_a) douta_q <= rd_a;
      if (acc_b) doutb_q <= rd_b;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [RAM_WIDTH-1:0] douta_p2_q, doutb_p2_q;
      logic                 rvalida_p2_q, rvalidb_p2_q;

      // Extra output stage advances every cycle; holding stage 1 keeps it holding too
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          douta_p2_q   <= '0;
          doutb_p2_q   <= '0;
          rvalida_p2_q <= 1'b0;
          rvalidb_p2_q <= 1'b0;
        end else begin
          douta_p2_q   <= douta_q;
          doutb_p2_q   <= doutb_q;
          rvalida_p2_q <= rvalida_q;
          rvalidb_p2_q <= rvalidb_q;
        end
      end

      assign bus.douta   = douta_p2_q;
      assign bus.doutb   = doutb_p2_q;
      assign bus.rvalida = rvalida_p2_q;
      assign bus.rvalidb = rvalidb_p2_q;
    end else begin : g_no_out_reg
      assign bus.douta   = douta_q;
      assign bus.doutb   = doutb_q;
      assign bus.rvalida = rvalida_q;
      assign bus.rvalidb = rvalidb_q;
    end
  endgenerate

  assign bus.init_done = ready;

endmodule

// File: tb/tb_dpram_tdp.sv
// Bench for dpram_tdp: two instances (OUT_REG=0 and OUT_REG=1) driven with
// identical stimulus and checked every cycle against an array-based model.
module tb_dpram_tdp;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dpram_tdp_if #(.RAM_WIDTH(W), .RAM_DEPTH(D)) if0 ();
  dpram_tdp_if #(.RAM_WIDTH(W), .RAM_DEPTH(D)) if1 ();

  dpram_tdp #(.RAM_WIDTH(W), .RAM_DEPTH(D), .OUT_REG(0), .INIT_ZERO(1))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  dpram_tdp #(.RAM_WIDTH(W), .RAM_DEPTH(D), .OUT_REG(1), .INIT_ZERO(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // stimulus
  logic          a_en, a_we, b_en, b_we, clr;
  logic [NB-1:0] a_stb, b_stb;
  logic [AW-1:0] a_addr, b_addr;
  logic [W-1:0]  a_din, b_din;

  // reference model
  logic [W-1:0] m_mem [D];
  logic [W-1:0] m_da, m_db, p_da, p_db;
  logic         m_va, m_vb, p_va, p_vb;
  int           busy;

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if0.ena = a_en;  if0.wea = a_we;  if0.wema = a_stb;  if0.addra = a_addr; if0.dina = a_din;
    if0.enb = b_en;  if0.web = b_we;  if0.wemb = b_stb;  if0.addrb = b_addr; if0.dinb = b_din;
    if0.clr_req = clr;
    if1.ena = a_en;  if1.wea = a_we;  if1.wema = a_stb;  if1.addra = a_addr; if1.dina = a_din;
    if1.enb = b_en;  if1.web = b_we;  if1.wemb = b_stb;  if1.addrb = b_addr; if1.dinb = b_din;
    if1.clr_req = clr;
  endtask

  task automatic idle_in();
    a_en = 0; a_we = 0; a_stb = '0; a_addr = '0; a_din = '0;
    b_en = 0; b_we = 0; b_stb = '0; b_addr = '0; b_din = '0;
    clr = 0;
  endtask

  task automatic rand_in(input int addr_hi, input int clr_odds);
    a_en = ($urandom_range(0, 9) < 7); a_we = $urandom_range(0, 1);
    b_en = ($urandom_range(0, 9) < 7); b_we = $urandom_range(0, 1);
    a_stb = NB'($urandom); b_stb = NB'($urandom);
    a_addr = AW'($urandom_range(0, addr_hi)); b_addr = AW'($urandom_range(0, addr_hi));
    a_din = $urandom; b_din = $urandom;
    clr = (clr_odds > 0) ? ($urandom_range(1, clr_odds) == 1) : 1'b0;
  endtask

  // One clock of the specified behaviour: ignore ports while filling, otherwise
  // read old contents, apply A's bytes then B's bytes (B wins on overlap).
  task automatic model_step();
    if (busy > 0) begin
      busy--;
      m_va = 0; m_vb = 0;
      if (busy == 0) for (int i = 0; i < D; i++) m_mem[i] = '0;
    end else begin
      m_va = a_en; m_vb = b_en;
      if (a_en) m_da = m_mem[a_addr];
      if (b_en) m_db = m_mem[b_addr];
      if (a_en && a_we)
        for (int i = 0; i < NB; i++) if (a_stb[i]) m_mem[a_addr][8*i +: 8] = a_din[8*i +: 8];
      if (b_en && b_we)
        for (int i = 0; i < NB; i++) if (b_stb[i]) m_mem[b_addr][8*i +: 8] = b_din[8*i +: 8];
      if (clr) busy = D;
    end
  endtask

  task automatic check_all();
    chk("douta_r0",   if0.douta, m_da);
    chk("doutb_r0",   if0.doutb, m_db);
    chk("rvalida_r0", 32'(if0.rvalida), 32'(m_va));
    chk("rvalidb_r0", 32'(if0.rvalidb), 32'(m_vb));
    chk("init_r0",    32'(if0.init_done), 32'(busy == 0));
    chk("douta_r1",   if1.douta, p_da);
    chk("doutb_r1",   if1.doutb, p_db);
    chk("rvalida_r1", 32'(if1.rvalida), 32'(p_va));
    chk("rvalidb_r1", 32'(if1.rvalidb), 32'(p_vb));
    chk("init_r1",    32'(if1.init_done), 32'(busy == 0));
  endtask

  // The OUT_REG=1 instance shows, after each edge, what the OUT_REG=0 one showed one edge earlier
  task automatic cycle();
    drive();
    @(posedge clk);
    #1;
    p_da = m_da; p_db = m_db; p_va = m_va; p_vb = m_vb;
    model_step();
    check_all();
  endtask

  task automatic apply_reset(input int ncyc);
    @(negedge clk);
    rst_n = 0;
    #1;
    m_da = '0; m_db = '0; m_va = 0; m_vb = 0;
    p_da = '0; p_db = '0; p_va = 0; p_vb = 0;
    busy = D;
    check_all();
    repeat (ncyc) @(negedge clk);
    check_all();
    rst_n = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    drive();
    for (int i = 0; i < D; i++) m_mem[i] = '1;
    #1;
    // backdoor preload so the fill has something to erase
    for (int i = 0; i < D; i++) begin
      dut0.mem[i] = '1;
      dut1.mem[i] = '1;
    end
    apply_reset(2);

    // Initial fill: ports hammered with writes that must be ignored
    for (int i = 1; i <= D; i++) begin
      rand_in(D - 1, 0);
      a_en = 1; a_we = 1; a_stb = '1; b_en = 1; b_we = 1; b_stb = '1;
      cycle();
      chk("clr_done_edge", 32'(if0.init_done), 32'(i == D));
    end

    // Every word reads back zero
    for (int i = 0; i < D; i++) begin
      idle_in();
      a_en = 1; a_addr = AW'(i); b_en = 1; b_addr = AW'(D - 1 - i);
      cycle();
      chk("zero_a", if0.douta, 32'h0);
      chk("zero_b", if0.doutb, 32'h0);
    end

    // Byte strobes on port B
    idle_in(); a_en = 1; a_we = 1; a_stb = 4'hF; a_addr = 4'd3; a_din = 32'h11223344; cycle();
    idle_in(); b_en = 1; b_we = 1; b_stb = 4'b0101; b_addr = 4'd3; b_din = 32'hAABBCCDD; cycle();
    idle_in(); b_en = 1; b_addr = 4'd3; cycle();
    chk("bstrobe_data", if0.doutb, 32'h11BB33DD);
    chk("bstrobe_vld1", 32'(if0.rvalidb), 32'd1);
    idle_in(); cycle();
    chk("bstrobe_r1_data", if1.doutb, 32'h11BB33DD);
    chk("bstrobe_r1_vld2", 32'(if1.rvalidb), 32'd1);

    // Cross-port read-first
    idle_in(); a_en = 1; a_we = 1; a_stb = 4'hF; a_addr = 4'd5; a_din = 32'hCAFEF00D; cycle();
    idle_in(); a_en = 1; a_we = 1; a_stb = 4'hF; a_addr = 4'd5; a_din = 32'h12345678;
    b_en = 1; b_addr = 4'd5; cycle();
    chk("rdfirst_old", if0.doutb, 32'hCAFEF00D);
    idle_in(); b_en = 1; b_addr = 4'd5; cycle();
    chk("rdfirst_new", if0.doutb, 32'h12345678);

    // Same-address double write
    idle_in(); a_en = 1; a_we = 1; a_stb = 4'hF; a_addr = 4'd7; a_din = 32'h11111111;
    b_en = 1; b_we = 1; b_stb = 4'b0011; b_addr = 4'd7; b_din = 32'h22222222; cycle();
    idle_in(); a_en = 1; a_addr = 4'd7; cycle();
    chk("collision", if0.douta, 32'h11112222);

    // Hold with ports disabled
    idle_in(); a_en = 1; a_we = 1; a_stb = 4'hF; a_addr = 4'd9; a_din = 32'hDEADBEEF; cycle();
    idle_in(); a_en = 1; a_addr = 4'd9; b_en = 1; b_addr = 4'd9; cycle();
    for (int i = 0; i < 5; i++) begin
      idle_in(); cycle();
      chk("hold_a", if0.douta, 32'hDEADBEEF);
      chk("hold_b", if0.doutb, 32'hDEADBEEF);
      chk("hold_va", 32'(if0.rvalida), 32'd0);
      chk("hold_vb", 32'(if0.rvalidb), 32'd0);
    end

    // clr_req together with an access: the read completes, then the fill starts
    idle_in(); a_en = 1; a_addr = 4'd9; clr = 1; cycle();
    chk("clr_acc_data", if0.douta, 32'hDEADBEEF);
    chk("clr_acc_vld", 32'(if0.rvalida), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      rand_in(D - 1, 0);
      clr = (i == 2);
      cycle();
      chk("clr_busy", 32'(if0.init_done), 32'd0);
    end
    // reset during fill cycle 6, then a full fill again; a clr_req inside is ignored
    idle_in(); drive();
    apply_reset(2);
    for (int i = 1; i <= D; i++) begin
      rand_in(D - 1, 0);
      clr = (i == 3);
      cycle();
      chk("refill_done_edge", 32'(if0.init_done), 32'(i == D));
    end
    idle_in(); a_en = 1; a_addr = 4'd9; cycle();
    chk("refill_zero", if0.douta, 32'h0);

    // Random traffic on a few addresses to provoke collisions, occasional clears
    for (int i = 0; i < 400; i++) begin
      rand_in(3, 120);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
